// File: rtl/debug_nav_pkg.sv
// Shared definitions for the debug-address navigator: idle levels, direction
// encodings and the wrap/saturate next-address arithmetic.
package debug_nav_pkg;

    // Wide enough for a 32-bit address plus one carry/borrow bit.
    localparam int unsigned NAV_W = 33;

    localparam logic IDLE_ROT = 1'b1;
    localparam logic IDLE_BTN = 1'b0;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    // Steps cur by +/-step inside [0, max_addr]; wraps modulo max_addr+1 or clamps.
    function automatic logic [NAV_W-1:0] nav_next_addr(
        input logic [NAV_W-1:0] cur,
        input logic [NAV_W-1:0] step,
        input logic [NAV_W-1:0] max_addr,
        input logic             inc,
        input logic             wrap
    );
        logic [NAV_W-1:0] span;
        logic [NAV_W-1:0] res;
        span = max_addr + NAV_W'(1);
        if (inc) begin
            res = cur + step;
            if (res > max_addr) begin
                res = wrap ? (res - span) : max_addr;
            end
        end else if (cur >= step) begin
            res = cur - step;
        end else begin
            res = wrap ? (cur + span - step) : '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/module_input_debouncer.sv
// Two-flop synchroniser, counting debouncer and rising-edge strobe for one
// raw asynchronous input.
module module_input_debouncer
    import debug_nav_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 62500,
    parameter logic        IDLE            = IDLE_BTN
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]       sync_q, sync_d;
    logic [1:0]       vld_q, vld_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             armed_q, armed_d;
    logic             sample;

    assign sample = sync_q[1];

    // vld marks when the synchroniser holds real samples rather than reset fill;
    // armed stays low until an idle sample is seen, so a press held through
    // reset never produces a rising edge.
    always_comb begin
        sync_d   = {sync_q[0], raw_i};
        vld_d    = {vld_q[0], 1'b1};
        stable_d = stable_q;
        cnt_d    = cnt_q;
        rise_d   = 1'b0;
        armed_d  = armed_q | (vld_q[1] & (sample == IDLE));

        if (sample == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = sample;
            cnt_d    = '0;
            rise_d   = sample & armed_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= {IDLE, IDLE};
            vld_q    <= '0;
            stable_q <= IDLE;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            vld_q    <= vld_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            armed_q  <= armed_d;
        end
    end

    assign level_o = stable_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/module_debug_address_navigator.sv
// Debug-address source: conditioned rotary encoder and buttons drive a wrap or
// saturate address register with coarse stepping, home and synchronous load.
module module_debug_address_navigator
    import debug_nav_pkg::*;
#(
    parameter int unsigned ADDR_W          = 8,
    parameter int unsigned MAX_ADDR        = (32'd1 << ADDR_W) - 32'd1,
    parameter int unsigned COARSE_STEP     = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 62500,
    parameter bit          WRAP_MODE       = 1'b1
) (
    input  logic              qzt_clk,
    input  logic              reset,
    input  logic              rot_a,
    input  logic              rot_b,
    input  logic              rot_center,
    input  logic              btn_home,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_value,
    output logic [ADDR_W-1:0] addr,
    output logic              step_pulse,
    output logic              direction,
    output logic              coarse,
    output logic              at_limit
);

    logic a_level, a_rise;
    logic b_level, b_rise;
    logic c_level, c_rise;
    logic h_level, h_rise;

    module_input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE(IDLE_ROT)) u_deb_a (
        .clk_i(qzt_clk), .rst_i(reset), .raw_i(rot_a), .level_o(a_level), .rise_o(a_rise)
    );
    module_input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE(IDLE_ROT)) u_deb_b (
        .clk_i(qzt_clk), .rst_i(reset), .raw_i(rot_b), .level_o(b_level), .rise_o(b_rise)
    );
    module_input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE(IDLE_BTN)) u_deb_c (
        .clk_i(qzt_clk), .rst_i(reset), .raw_i(rot_center), .level_o(c_level), .rise_o(c_rise)
    );
    module_input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE(IDLE_BTN)) u_deb_h (
        .clk_i(qzt_clk), .rst_i(reset), .raw_i(btn_home), .level_o(h_level), .rise_o(h_rise)
    );

    // Only B's level and the A/center/home edges drive behaviour here.
    logic debounce_unused;
    assign debounce_unused = ^{a_level, b_rise, c_level, h_level};

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              step_pulse_q, step_pulse_d;
    logic              direction_q, direction_d;
    logic              coarse_q, coarse_d;
    logic              at_limit_q, at_limit_d;

    logic              detent_dir;
    logic [NAV_W-1:0]  step_size;
    logic [NAV_W-1:0]  stepped;
    logic [ADDR_W-1:0] load_clamped;

    // Priority: load > home > detent; flags follow the detent regardless.
    always_comb begin
        detent_dir   = b_level ? DIR_CCW : DIR_CW;
        step_size    = coarse_q ? NAV_W'(COARSE_STEP) : NAV_W'(1);
        stepped      = nav_next_addr(NAV_W'(addr_q), step_size, NAV_W'(MAX_ADDR),
                                     detent_dir == DIR_CW, WRAP_MODE);
        load_clamped = (32'(load_value) > MAX_ADDR) ? ADDR_W'(MAX_ADDR) : load_value;

        addr_d       = addr_q;
        step_pulse_d = a_rise;
        direction_d  = direction_q;
        coarse_d     = coarse_q ^ c_rise;

        if (a_rise) begin
            direction_d = detent_dir;
        end

        if (load) begin
            addr_d = load_clamped;
        end else if (h_rise) begin
            addr_d = '0;
        end else if (a_rise) begin
            addr_d = ADDR_W'(stepped);
        end

        at_limit_d = (addr_d == '0) || (addr_d == ADDR_W'(MAX_ADDR));
    end

    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            addr_q       <= '0;
            step_pulse_q <= 1'b0;
            direction_q  <= DIR_CW;
            coarse_q     <= 1'b0;
            at_limit_q   <= 1'b1;
        end else begin
            addr_q       <= addr_d;
            step_pulse_q <= step_pulse_d;
            direction_q  <= direction_d;
            coarse_q     <= coarse_d;
            at_limit_q   <= at_limit_d;
        end
    end

    assign addr       = addr_q;
    assign step_pulse = step_pulse_q;
    assign direction  = direction_q;
    assign coarse     = coarse_q;
    assign at_limit   = at_limit_q;

endmodule

// File: tb/tb_module_debug_address_navigator.sv
// Bench for module_debug_address_navigator: a wrapping (MAX 255) and a
// saturating (MAX 199) instance share stimulus; directed scenarios plus a
// randomized run against a behavioural reference model.
module tb_module_debug_address_navigator;

    localparam int unsigned DB  = 4;
    // One negedge to reach the sampling edge, then 2+DB cycles to the outputs.
    localparam int          LAT = DB + 3;

    logic       qzt_clk = 1'b0;
    logic       reset = 1'b1;
    logic       rot_a = 1'b1, rot_b = 1'b1, rot_center = 1'b0, btn_home = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_value = 8'd0;

    logic [7:0] addr_w, addr_s;
    logic       step_pulse_w, direction_w, coarse_w, at_limit_w;
    logic       step_pulse_s, direction_s, coarse_s, at_limit_s;

    int total = 0;
    int bad   = 0;

    always #5 qzt_clk = ~qzt_clk;

    module_debug_address_navigator #(
        .ADDR_W(8), .MAX_ADDR(255), .COARSE_STEP(16), .DEBOUNCE_CYCLES(DB), .WRAP_MODE(1'b1)
    ) dut_w (
        .qzt_clk(qzt_clk), .reset(reset), .rot_a(rot_a), .rot_b(rot_b),
        .rot_center(rot_center), .btn_home(btn_home), .load(load), .load_value(load_value),
        .addr(addr_w), .step_pulse(step_pulse_w), .direction(direction_w),
        .coarse(coarse_w), .at_limit(at_limit_w)
    );

    module_debug_address_navigator #(
        .ADDR_W(8), .MAX_ADDR(199), .COARSE_STEP(16), .DEBOUNCE_CYCLES(DB), .WRAP_MODE(1'b0)
    ) dut_s (
        .qzt_clk(qzt_clk), .reset(reset), .rot_a(rot_a), .rot_b(rot_b),
        .rot_center(rot_center), .btn_home(btn_home), .load(load), .load_value(load_value),
        .addr(addr_s), .step_pulse(step_pulse_s), .direction(direction_s),
        .coarse(coarse_s), .at_limit(at_limit_s)
    );

    logic [7:0] o_addr [2];
    logic       o_step [2], o_dir [2], o_coarse [2], o_lim [2];
    assign o_addr[0] = addr_w;       assign o_addr[1] = addr_s;
    assign o_step[0] = step_pulse_w; assign o_step[1] = step_pulse_s;
    assign o_dir[0]  = direction_w;  assign o_dir[1]  = direction_s;
    assign o_coarse[0] = coarse_w;   assign o_coarse[1] = coarse_s;
    assign o_lim[0]  = at_limit_w;   assign o_lim[1]  = at_limit_s;

    // Reference model. Inputs 0..3 = rot_a, rot_b, rot_center, btn_home.
    // A sample value of 2 marks synchroniser fill after reset (idle, not real).
    int m_addr [2];
    bit m_lim [2];
    bit m_step, m_dir, m_coarse;
    bit lvl [4], armed [4], rise [4];
    int sq [4][$];
    int win [4][$];

    function automatic int max_of(input int d);
        return (d == 0) ? 255 : 199;
    endfunction

    function automatic bit idle_of(input int i);
        return (i < 2);
    endfunction

    always @(posedge qzt_clk) begin : ref_model
        bit raw [4];
        raw[0] = rot_a; raw[1] = rot_b; raw[2] = rot_center; raw[3] = btn_home;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                sq[i] = '{2, 2};
                win[i].delete();
                lvl[i] = idle_of(i); armed[i] = 1'b0; rise[i] = 1'b0;
            end
            for (int d = 0; d < 2; d++) begin m_addr[d] = 0; m_lim[d] = 1'b1; end
            m_step = 1'b0; m_dir = 1'b1; m_coarse = 1'b0;
        end else begin
            int s;
            s = m_coarse ? 16 : 1;
            m_step = rise[0];
            if (rise[0]) m_dir = !lvl[1];
            if (rise[2]) m_coarse = !m_coarse;
            for (int d = 0; d < 2; d++) begin
                int ma, na;
                ma = max_of(d);
                na = m_addr[d];
                if (load) na = (int'(load_value) > ma) ? ma : int'(load_value);
                else if (rise[3]) na = 0;
                else if (rise[0]) begin
                    if (d == 0) na = lvl[1] ? (na - s + ma + 1) % (ma + 1) : (na + s) % (ma + 1);
                    else begin
                        na = lvl[1] ? na - s : na + s;
                        if (na < 0) na = 0;
                        if (na > ma) na = ma;
                    end
                end
                m_addr[d] = na;
                m_lim[d] = (na == 0) || (na == ma);
            end
            for (int i = 0; i < 4; i++) begin
                int  seen;
                bit  v, all_diff, was_armed;
                seen = sq[i].pop_front();
                sq[i].push_back(int'(raw[i]));
                v = (seen == 2) ? idle_of(i) : seen[0];
                was_armed = armed[i];
                if (seen != 2 && v == idle_of(i)) armed[i] = 1'b1;
                win[i].push_back(int'(v));
                if (win[i].size() > DB) void'(win[i].pop_front());
                all_diff = (win[i].size() == DB);
                foreach (win[i][k]) if (win[i][k] == int'(lvl[i])) all_diff = 1'b0;
                rise[i] = 1'b0;
                if (all_diff) begin
                    lvl[i] = v;
                    win[i].delete();
                    rise[i] = v && was_armed;
                end
            end
        end
    end

    task automatic idle_wait(input int n);
        repeat (n) @(negedge qzt_clk);
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1; load_value = v;
        @(negedge qzt_clk);
        load = 1'b0;
    endtask

    task automatic detent(input bit cw, output int pulses, output int lat);
        rot_b = cw ? 1'b0 : 1'b1; rot_a = 1'b0;
        idle_wait(10);
        rot_a = 1'b1; pulses = 0; lat = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge qzt_clk);
            if (step_pulse_w === 1'b1) begin pulses++; if (lat < 0) lat = i; end
        end
    endtask

    task automatic press_center();
        rot_center = 1'b1; idle_wait(12);
        rot_center = 1'b0; idle_wait(12);
    endtask

    task automatic test_reset();
        logic [7:0] got [10];
        reset = 1'b1;
        idle_wait(3);
        got = '{addr_w, step_pulse_w, direction_w, coarse_w, at_limit_w,
                addr_s, step_pulse_s, direction_s, coarse_s, at_limit_s};
        for (int i = 0; i < 10; i++) begin
            logic [7:0] want;
            case (i % 5)
                0: want = 8'd0; 1: want = 8'd0; 2: want = 8'd1; 3: want = 8'd0; default: want = 8'd1;
            endcase
            total++;
            if (got[i] !== want) begin bad++; $display("FAIL reset_out%0d: got %0d want %0d", i, got[i], want); end
        end
        reset = 1'b0;
        idle_wait(10);
    endtask

    task automatic test_wrap_top();
        int p, l;
        int exp_a [3] = '{255, 0, 1};
        bit exp_l [3] = '{1'b1, 1'b1, 1'b0};
        do_load(8'd254);
        total++; if (addr_w !== 8'd254) begin bad++; $display("FAIL wrap_load: got %0d want 254", addr_w); end
        total++; if (at_limit_w !== 1'b0) begin bad++; $display("FAIL wrap_load_lim: got %0b want 0", at_limit_w); end
        for (int k = 0; k < 3; k++) begin
            detent(1'b1, p, l);
            total++; if (p != 1) begin bad++; $display("FAIL wrap_pulses[%0d]: got %0d want 1", k, p); end
            total++; if (l != LAT) begin bad++; $display("FAIL wrap_latency[%0d]: got %0d want %0d", k, l, LAT); end
            total++; if (addr_w !== 8'(exp_a[k])) begin bad++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", k, addr_w, exp_a[k]); end
            total++; if (at_limit_w !== exp_l[k]) begin bad++; $display("FAIL wrap_lim[%0d]: got %0b want %0b", k, at_limit_w, exp_l[k]); end
            total++; if (direction_w !== 1'b1) begin bad++; $display("FAIL wrap_dir[%0d]: got %0b want 1", k, direction_w); end
        end
    endtask

    task automatic test_saturate();
        int p, l;
        do_load(8'd250);
        total++; if (addr_s !== 8'd199) begin bad++; $display("FAIL sat_load_clamp: got %0d want 199", addr_s); end
        total++; if (at_limit_s !== 1'b1) begin bad++; $display("FAIL sat_load_lim: got %0b want 1", at_limit_s); end
        total++; if (addr_w !== 8'd250) begin bad++; $display("FAIL wrapdut_load: got %0d want 250", addr_w); end
        press_center();
        total++; if (coarse_s !== 1'b1) begin bad++; $display("FAIL sat_coarse_on: got %0b want 1", coarse_s); end
        detent(1'b0, p, l);
        total++; if (addr_s !== 8'd183) begin bad++; $display("FAIL sat_ccw1: got %0d want 183", addr_s); end
        total++; if (direction_s !== 1'b0) begin bad++; $display("FAIL sat_dir: got %0b want 0", direction_s); end
        detent(1'b0, p, l);
        total++; if (addr_s !== 8'd167) begin bad++; $display("FAIL sat_ccw2: got %0d want 167", addr_s); end
        do_load(8'd5);
        detent(1'b0, p, l);
        total++; if (addr_s !== 8'd0) begin bad++; $display("FAIL sat_floor: got %0d want 0", addr_s); end
        total++; if (at_limit_s !== 1'b1) begin bad++; $display("FAIL sat_floor_lim: got %0b want 1", at_limit_s); end
        total++; if (addr_w !== 8'd245) begin bad++; $display("FAIL wrap_under: got %0d want 245", addr_w); end
    endtask

    task automatic test_reset_mid_bounce();
        int p, l;
        rot_a = 1'b0;
        idle_wait(4);
        reset = 1'b1; rot_b = 1'b0;
        @(negedge qzt_clk);
        total++; if ({addr_w, addr_s} !== 16'd0) begin bad++; $display("FAIL rmb_addr: got %0d/%0d want 0/0", addr_w, addr_s); end
        total++; if ({step_pulse_w, direction_w, coarse_w, at_limit_w} !== 4'b0101) begin
            bad++; $display("FAIL rmb_flags: got %b want 0101", {step_pulse_w, direction_w, coarse_w, at_limit_w}); end
        total++; if (coarse_s !== 1'b0) begin bad++; $display("FAIL rmb_coarse_s: got %0b want 0", coarse_s); end
        reset = 1'b0;
        p = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge qzt_clk);
            if (step_pulse_w === 1'b1) p++;
        end
        total++; if (p != 0) begin bad++; $display("FAIL rmb_no_pulse_low: got %0d want 0", p); end
        rot_a = 1'b1; p = 0; l = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge qzt_clk);
            if (step_pulse_w === 1'b1) begin p++; if (l < 0) l = i; end
        end
        total++; if (p != 1) begin bad++; $display("FAIL rmb_pulses: got %0d want 1", p); end
        total++; if (l != LAT) begin bad++; $display("FAIL rmb_latency: got %0d want %0d", l, LAT); end
        total++; if ({addr_w, addr_s} !== {8'd1, 8'd1}) begin bad++; $display("FAIL rmb_addr_after: got %0d/%0d want 1/1", addr_w, addr_s); end
    endtask

    task automatic test_bounce();
        int p, l;
        rot_b = 1'b0; rot_a = 1'b0;
        idle_wait(10);
        p = 0; l = -1;
        for (int i = 0; i < 10; i++) begin
            rot_a = (i % 2 == 0);
            repeat (2) begin @(negedge qzt_clk); if (step_pulse_w === 1'b1) p++; end
        end
        rot_a = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge qzt_clk);
            if (step_pulse_w === 1'b1) begin p++; if (l < 0) l = i; end
        end
        total++; if (p != 1) begin bad++; $display("FAIL bounce_pulses: got %0d want 1", p); end
        total++; if (l != LAT) begin bad++; $display("FAIL bounce_latency: got %0d want %0d", l, LAT); end
        total++; if (addr_w !== 8'd2) begin bad++; $display("FAIL bounce_addr: got %0d want 2", addr_w); end
    endtask

    task automatic test_simultaneous();
        rot_b = 1'b0; rot_a = 1'b0;
        idle_wait(10);
        rot_a = 1'b1;
        idle_wait(LAT - 1);
        load = 1'b1; load_value = 8'h42;
        @(negedge qzt_clk);
        load = 1'b0;
        total++; if (addr_w !== 8'h42) begin bad++; $display("FAIL sim_load_addr: got %0h want 42", addr_w); end
        total++; if (step_pulse_w !== 1'b1) begin bad++; $display("FAIL sim_load_pulse: got %0b want 1", step_pulse_w); end
        total++; if (addr_s !== 8'h42) begin bad++; $display("FAIL sim_load_addr_s: got %0h want 42", addr_s); end
        idle_wait(4);
        total++; if (addr_w !== 8'h42) begin bad++; $display("FAIL sim_load_hold: got %0h want 42", addr_w); end
        rot_a = 1'b0;
        idle_wait(10);
        rot_a = 1'b1; btn_home = 1'b1;
        idle_wait(LAT);
        total++; if (addr_w !== 8'd0) begin bad++; $display("FAIL sim_home_addr: got %0d want 0", addr_w); end
        total++; if (step_pulse_w !== 1'b1) begin bad++; $display("FAIL sim_home_pulse: got %0b want 1", step_pulse_w); end
        total++; if (at_limit_w !== 1'b1) begin bad++; $display("FAIL sim_home_lim: got %0b want 1", at_limit_w); end
        btn_home = 1'b0;
        idle_wait(12);
    endtask

    task automatic test_center();
        bit exp_c [3] = '{1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            rot_center = 1'b1;
            idle_wait(LAT - 1);
            total++; if (coarse_w !== !exp_c[k]) begin bad++; $display("FAIL center_early[%0d]: got %0b want %0b", k, coarse_w, !exp_c[k]); end
            @(negedge qzt_clk);
            total++; if (coarse_w !== exp_c[k]) begin bad++; $display("FAIL center_toggle[%0d]: got %0b want %0b", k, coarse_w, exp_c[k]); end
            rot_center = 1'b0;
            idle_wait(12);
        end
        rot_center = 1'b1;
        idle_wait(12);
        reset = 1'b1;
        idle_wait(2);
        reset = 1'b0;
        idle_wait(20);
        total++; if (coarse_w !== 1'b0) begin bad++; $display("FAIL center_held_reset: got %0b want 0", coarse_w); end
        rot_center = 1'b0;
        idle_wait(12);
        total++; if (coarse_s !== 1'b0) begin bad++; $display("FAIL center_release: got %0b want 0", coarse_s); end
        press_center();
        total++; if (coarse_w !== 1'b1) begin bad++; $display("FAIL center_repress: got %0b want 1", coarse_w); end
    endtask

    task automatic test_random();
        int hold [4];
        bit val [4];
        val = '{rot_a, rot_b, rot_center, btn_home};
        hold = '{0, 0, 0, 0};
        for (int cyc = 0; cyc < 2500; cyc++) begin
            @(negedge qzt_clk);
            for (int d = 0; d < 2; d++) begin
                total++; if (o_addr[d] !== 8'(m_addr[d])) begin bad++; $display("FAIL rand_addr d%0d c%0d: got %0d want %0d", d, cyc, o_addr[d], m_addr[d]); end
                total++; if (o_step[d] !== m_step) begin bad++; $display("FAIL rand_step d%0d c%0d: got %0b want %0b", d, cyc, o_step[d], m_step); end
                total++; if (o_dir[d] !== m_dir) begin bad++; $display("FAIL rand_dir d%0d c%0d: got %0b want %0b", d, cyc, o_dir[d], m_dir); end
                total++; if (o_coarse[d] !== m_coarse) begin bad++; $display("FAIL rand_coarse d%0d c%0d: got %0b want %0b", d, cyc, o_coarse[d], m_coarse); end
                total++; if (o_lim[d] !== m_lim[d]) begin bad++; $display("FAIL rand_lim d%0d c%0d: got %0b want %0b", d, cyc, o_lim[d], m_lim[d]); end
            end
            reset = ($urandom_range(0, 599) == 0);
            load = ($urandom_range(0, 24) == 0);
            load_value = 8'($urandom);
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    val[i] = 1'($urandom_range(0, 1));
                    hold[i] = $urandom_range(1, 9);
                end
                hold[i]--;
            end
            rot_a = val[0]; rot_b = val[1]; rot_center = val[2]; btn_home = val[3];
        end
        reset = 1'b0; load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap_top();
        test_saturate();
        test_reset_mid_bounce();
        test_bounce();
        test_simultaneous();
        test_center();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
